// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : enc_pkg
// Brief   : Shared types and round-function helpers for the nibble-cipher
//           round sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int ROUND_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit permutation/duplication of the low nibble into a full byte
    function automatic logic [7:0] expand(input logic [3:0] n);
        return {n[3], n[0], n[1], n[2], n[1], n[3], n[2], n[0]};
    endfunction

    function automatic logic [7:0] round_f(input logic [7:0] n, input logic [7:0] k);
        logic [7:0] x;
        logic [3:0] s;
        x = expand(n[3:0]) ^ k;
        s = x[7:4] + x[3:0] + {3'b000, k[0]};
        return {n[7:4] ^ s, n[3:0]};
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_round.sv
`default_nettype none
// ============================================================================
// Module  : enc_round
// Brief   : Combinational single round F(n,k) of the nibble cipher.
// Revision: 1.0 - initial release
// ============================================================================
module enc_round
    import enc_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic [7:0] i_key,
    output logic [7:0] o_data
);

    logic [7:0] w_exp;
    logic [7:0] w_x;
    logic [3:0] w_sum0;
    logic [3:0] w_sum1;
    logic [3:0] w_s;

    assign w_exp = expand(i_data[3:0]);
    assign w_x   = w_exp ^ i_key;

    // Carry-select: both carry-in sums precomputed, key bit 0 picks one
    assign w_sum0 = w_x[7:4] + w_x[3:0];
    assign w_sum1 = w_x[7:4] + w_x[3:0] + 4'd1;
    assign w_s    = i_key[0] ? w_sum1 : w_sum0;

    assign o_data = {i_data[7:4] ^ w_s, i_data[3:0]};

endmodule : enc_round
`default_nettype wire

// File: rtl/enc_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : enc_round_sequencer
// Brief   : Multi-round controller: accepts byte+key, runs ROUNDS rounds at
//           one per clock, presents the result on a valid/ready output.
//           Optional abort input when ENC_SEQ_ABORT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module enc_round_sequencer
    import enc_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] in_key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic [3:0] round_idx
`ifdef ENC_SEQ_ABORT_EN
    ,
    input  logic       abort
`endif
);

    generate
        if (ROUNDS < 1 || ROUNDS > 15) begin : g_rounds_bad
            $error("enc_round_sequencer: ROUNDS must be in 1..15");
        end
    endgenerate

    localparam logic [ROUND_W-1:0] c_last = ROUND_W'(ROUNDS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_data;
    logic [7:0]         r_key;
    logic [ROUND_W-1:0] r_round;
    logic [7:0]         r_out;
    logic [7:0]         w_f;
    logic               w_last;
    logic               w_abort;

`ifdef ENC_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    enc_round u_round (
        .i_data (r_data),
        .i_key  (r_key),
        .o_data (w_f)
    );

    assign w_last = (r_round == c_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_abort || out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_key   <= 8'h00;
            r_round <= '0;
            r_out   <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_key   <= in_key;
                        r_round <= '0;
                    end
                end
                RUN: begin
                    if (!w_last) begin
                        r_data  <= {w_f[3:0], w_f[7:4]};
                        r_key   <= {r_key[6:0], r_key[7]};
                        r_round <= r_round + 4'd1;
                    end else begin
                        // An aborted final round must not disturb the held result
                        if (!w_abort) begin
                            r_out <= w_f;
                        end
                        r_round <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign round_idx = (r_state == RUN) ? r_round : 4'd0;
    assign out_data  = r_out;

endmodule : enc_round_sequencer
`default_nettype wire

// File: tb/tb_enc_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_enc_round_sequencer
// Brief   : Self-checking bench driving three sequencers (ROUNDS=1,2,4)
//           against a behavioural cipher model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_enc_round_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_valid  = '0;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] out_ready = '0;
    logic [2:0] busy;
    logic [7:0] in_data   [3];
    logic [7:0] in_key    [3];
    logic [7:0] out_data  [3];
    logic [3:0] round_idx [3];
`ifdef ENC_SEQ_ABORT_EN
    logic [2:0] abort = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        enc_round_sequencer #(.ROUNDS(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clock     (clk),
            .reset     (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_key    (in_key[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g]),
            .round_idx (round_idx[g])
`ifdef ENC_SEQ_ABORT_EN
            ,
            .abort     (abort[g])
`endif
        );
    end

    function automatic int rounds_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    // Cipher computed straight from the round rules with integer arithmetic
    function automatic logic [7:0] model(input logic [7:0] data, input logic [7:0] key,
                                         input int rounds);
        int sel [8] = '{0, 2, 3, 1, 2, 1, 0, 3};
        int n = int'(data);
        int k = int'(key);
        int e, x, s, f;
        for (int r = 0; r < rounds; r++) begin
            e = 0;
            for (int i = 0; i < 8; i++) e = e | (((n >> sel[i]) & 1) << i);
            x = e ^ k;
            s = ((x >> 4) + (x & 15) + (k & 1)) % 16;
            f = ((((n >> 4) ^ s) & 15) << 4) | (n & 15);
            if (r != rounds - 1) begin
                n = ((f & 15) << 4) | (f >> 4);
                k = ((k << 1) | (k >> 7)) & 255;
            end else begin
                n = f;
            end
        end
        return n[7:0];
    endfunction

    task automatic check(input int d, input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check(d, {tag, "_in_ready"},  32'(in_ready[d]),  32'd1);
        check(d, {tag, "_out_valid"}, 32'(out_valid[d]), 32'd0);
        check(d, {tag, "_busy"},      32'(busy[d]),      32'd0);
        check(d, {tag, "_round_idx"}, 32'(round_idx[d]), 32'd0);
    endtask

    // One full operation; in_valid stays high with junk afterwards to prove no overlap
    task automatic do_op(input int d, input logic [7:0] data, input logic [7:0] key,
                         input logic [7:0] exp, input int hold);
        int r = rounds_of(d);
        @(negedge clk);
        check(d, "accept_ready", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_key[d]   = key;
        @(negedge clk);
        for (int i = 0; i < r; i++) begin
            in_data[d]   = 8'($urandom);
            in_key[d]    = 8'($urandom);
            check(d, "run_busy",      32'(busy[d]),      32'd1);
            check(d, "run_round_idx", 32'(round_idx[d]), 32'(i));
            check(d, "run_out_valid", 32'(out_valid[d]), 32'd0);
            check(d, "run_in_ready",  32'(in_ready[d]),  32'd0);
            out_ready[d] = 1'($urandom);
            @(negedge clk);
        end
        out_ready[d] = 1'b0;
        check(d, "done_out_valid", 32'(out_valid[d]), 32'd1);
        check(d, "done_out_data",  32'(out_data[d]),  32'(exp));
        check(d, "done_round_idx", 32'(round_idx[d]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check(d, "hold_out_valid", 32'(out_valid[d]), 32'd1);
            check(d, "hold_out_data",  32'(out_data[d]),  32'(exp));
            check(d, "hold_in_ready",  32'(in_ready[d]),  32'd0);
            check(d, "hold_busy",      32'(busy[d]),      32'd1);
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check_idle(d, "release");
        in_valid[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] d8, k8;
        for (int d = 0; d < 3; d++) begin
            in_data[d] = 8'h00;
            in_key[d]  = 8'h00;
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_idle(d, "reset");
            check(d, "reset_out_data", 32'(out_data[d]), 32'd0);
        end
        rst = 1'b0;

        // Directed vectors
        do_op(0, 8'h46, 8'h93, 8'h06, 0);
        do_op(0, 8'hC9, 8'hAC, 8'h39, 1);
        do_op(1, 8'h46, 8'h93, 8'hC0, 0);
        do_op(1, 8'h46, 8'h93, 8'hC0, 5);
        do_op(2, 8'h46, 8'h93, model(8'h46, 8'h93, 4), 5);

        // Randomised operations on every instance
        for (int it = 0; it < 8; it++) begin
            for (int d = 0; d < 3; d++) begin
                d8 = 8'($urandom);
                k8 = 8'($urandom);
                do_op(d, d8, k8, model(d8, k8, rounds_of(d)), int'($urandom_range(0, 3)));
            end
        end

        // Reset in the middle of a ROUNDS=4 operation
        do_op(2, 8'h5A, 8'h3C, model(8'h5A, 8'h3C, 4), 0);
        @(negedge clk);
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h46;
        in_key[2]   = 8'h93;
        @(negedge clk);
        in_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(2, "midrun_round_idx", 32'(round_idx[2]), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(2, "midrun_reset");
        check(2, "midrun_reset_out_data", 32'(out_data[2]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check(2, "post_reset_out_valid", 32'(out_valid[2]), 32'd0);
            check(2, "post_reset_busy",      32'(busy[2]),      32'd0);
        end

`ifdef ENC_SEQ_ABORT_EN
        // Abort during RUN
        @(negedge clk);
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h46;
        in_key[2]   = 8'h93;
        @(negedge clk);
        in_valid[2] = 1'b0;
        check(2, "abort_pre_busy", 32'(busy[2]), 32'd1);
        abort[2] = 1'b1;
        @(negedge clk);
        abort[2] = 1'b0;
        check_idle(2, "abort_run");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check(2, "abort_no_valid", 32'(out_valid[2]), 32'd0);
        end

        // Abort while IDLE must not block acceptance
        abort[1]    = 1'b1;
        in_valid[1] = 1'b1;
        d8 = 8'($urandom);
        k8 = 8'($urandom);
        in_data[1]  = d8;
        in_key[1]   = k8;
        @(negedge clk);
        abort[1]    = 1'b0;
        in_valid[1] = 1'b0;
        check(1, "abort_idle_busy",      32'(busy[1]),      32'd1);
        check(1, "abort_idle_round_idx", 32'(round_idx[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check(1, "abort_idle_result_valid", 32'(out_valid[1]), 32'd1);
        check(1, "abort_idle_result_data",  32'(out_data[1]),  32'(model(d8, k8, 2)));

        // Abort together with out_ready in DONE
        abort[1]     = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        abort[1]     = 1'b0;
        out_ready[1] = 1'b0;
        check_idle(1, "abort_done");
        do_op(1, 8'h46, 8'h93, 8'hC0, 1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_enc_round_sequencer
`default_nettype wire
